serial_io_hub: RTL and testbench



---
 rtl/serial_io_hub.sv | 146 ++++++++++++++
 tb/tb_serial_io_hub.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_hub.sv
// Memory-mapped hub for CHANNELS byte-serial links: per-channel TX/RX FIFOs,
// sticky overflow flags and a level interrupt on pending RX data.
module serial_io_hub_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

module serial_io_hub #(
    parameter int          CHANNELS        = 2,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] BASE_ADDR       = 16'hBF00,
    parameter bit          RX_BACKPRESSURE = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [15:0]           i_addr,
    input  logic [15:0]           i_wdata,
    input  logic [1:0]            i_mem_rw,
    output logic [15:0]           o_rdata,
    output logic                  o_hit,
    output logic [8*CHANNELS-1:0] o_tx_data,
    output logic [CHANNELS-1:0]   o_tx_valid,
    input  logic [CHANNELS-1:0]   i_tx_ready,
    input  logic [8*CHANNELS-1:0] i_rx_data,
    input  logic [CHANNELS-1:0]   i_rx_valid,
    output logic [CHANNELS-1:0]   o_rx_ready,
    output logic                  o_irq
);
    localparam logic [15:0] IRQEN_OFF = 16'(2 * CHANNELS);

    logic [15:0]                w_off;
    logic                       w_rd, w_wr, w_irqen_sel, w_stat;
    logic [CHANNELS-1:0]        w_sel, w_stat_rd;
    logic [CHANNELS-1:0]        w_tx_empty, w_tx_full, w_tx_drop;
    logic [CHANNELS-1:0]        w_rx_empty, w_rx_full, w_rx_drop;
    logic [CHANNELS-1:0][7:0]   w_rx_head;
    logic [CHANNELS-1:0]        r_tx_ovf, r_rx_ovf, r_irqen;
    logic                       r_irq;
    logic                       w_unused;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of window.
    assign w_off       = i_addr - BASE_ADDR;
    assign o_hit       = (w_off <= IRQEN_OFF);
    assign w_irqen_sel = o_hit & (w_off == IRQEN_OFF);
    assign w_stat      = w_off[0];
    assign w_rd        = (i_mem_rw == 2'b01);
    assign w_wr        = (i_mem_rw == 2'b10);
    assign w_unused    = &{1'b0, i_wdata[15:8]};

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic w_tx_push, w_rx_push, w_rx_pop;

        assign w_sel[n]     = o_hit & ~w_irqen_sel & (w_off[15:1] == 15'(n));
        assign w_tx_push    = w_wr & w_sel[n] & ~w_stat;
        assign w_rx_pop     = w_rd & w_sel[n] & ~w_stat;
        assign w_stat_rd[n] = w_rd & w_sel[n] & w_stat;
        assign o_tx_valid[n] = ~w_tx_empty[n] & ~i_rst;
        assign o_rx_ready[n] = RX_BACKPRESSURE ? (~w_rx_full[n] & ~i_rst) : 1'b1;
        assign w_rx_push    = i_rx_valid[n] & o_rx_ready[n];

        serial_io_hub_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_push(w_tx_push), .i_pop(o_tx_valid[n] & i_tx_ready[n]),
            .i_data(i_wdata[7:0]), .o_head(o_tx_data[8*n +: 8]),
            .o_empty(w_tx_empty[n]), .o_full(w_tx_full[n]), .o_drop(w_tx_drop[n])
        );

        serial_io_hub_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_push(w_rx_push), .i_pop(w_rx_pop),
            .i_data(i_rx_data[8*n +: 8]), .o_head(w_rx_head[n]),
            .o_empty(w_rx_empty[n]), .o_full(w_rx_full[n]), .o_drop(w_rx_drop[n])
        );
    end

    // Set beats clear when a drop coincides with the STATUS read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_ovf <= '0;
            r_rx_ovf <= '0;
            r_irqen  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_tx_ovf <= (r_tx_ovf & ~w_stat_rd) | w_tx_drop;
            r_rx_ovf <= (r_rx_ovf & ~w_stat_rd) | w_rx_drop;
            if (w_wr & w_irqen_sel) r_irqen <= i_wdata[CHANNELS-1:0];
            r_irq <= |(r_irqen & ~w_rx_empty);
        end
    end

    assign o_irq = r_irq;

    always_comb begin
        o_rdata = 16'h0000;
        if (w_irqen_sel) o_rdata[CHANNELS-1:0] = r_irqen;
        for (int n = 0; n < CHANNELS; n++) begin
            if (w_sel[n]) begin
                if (w_stat)
                    o_rdata[3:0] = {r_tx_ovf[n], r_rx_ovf[n], ~w_rx_empty[n], ~w_tx_full[n]};
                else if (!w_rx_empty[n])
                    o_rdata[7:0] = w_rx_head[n];
            end
        end
    end
endmodule

// File: tb/tb_serial_io_hub.sv
// Directed bench: one hub with RX backpressure, one without, sharing stimulus.
module tb_serial_io_hub;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, wdata, rdata, nb_rdata;
    logic [1:0]  mem_rw;
    logic        hit, nb_hit, irq, nb_irq;
    logic [15:0] tx_data, nb_tx_data, rx_data;
    logic [1:0]  tx_valid, nb_tx_valid, tx_ready, rx_valid, rx_ready, nb_rx_ready;
    logic [15:0] d, dn;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    serial_io_hub #(.CHANNELS(2), .FIFO_DEPTH(4), .BASE_ADDR(16'hBF00), .RX_BACKPRESSURE(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_mem_rw(mem_rw),
        .o_rdata(rdata), .o_hit(hit), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready), .o_irq(irq));

    serial_io_hub #(.CHANNELS(2), .FIFO_DEPTH(4), .BASE_ADDR(16'hBF00), .RX_BACKPRESSURE(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_mem_rw(mem_rw),
        .o_rdata(nb_rdata), .o_hit(nb_hit), .o_tx_data(nb_tx_data), .o_tx_valid(nb_tx_valid),
        .i_tx_ready(tx_ready), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(nb_rx_ready), .o_irq(nb_irq));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] v);
        addr = a; wdata = v; mem_rw = 2'b10;
        cyc();
        mem_rw = 2'b00;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [15:0] v, output logic [15:0] vn);
        addr = a; mem_rw = 2'b01;
        #1 v = rdata; vn = nb_rdata;
        cyc();
        mem_rw = 2'b00;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] v, output logic [15:0] vn);
        addr = a; mem_rw = 2'b00;
        #1 v = rdata; vn = nb_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_rw = 2'b00; tx_ready = 2'b00; rx_valid = 2'b00;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; addr = 16'h0; wdata = 16'h0; mem_rw = 2'b00;
        tx_ready = 2'b00; rx_data = 16'h0; rx_valid = 2'b00;
        cyc();
        chk("rst_tx_valid", tx_valid, 2'b00);
        chk("rst_rx_ready_bp", rx_ready, 2'b00);
        chk("rst_rx_ready_nobp", nb_rx_ready, 2'b11);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        #1 chk("post_rst_rx_ready", rx_ready, 2'b11);
        peek(16'hBF01, d, dn); chk("rst_status0", d, 16'h0001);
        peek(16'hBF04, d, dn); chk("hit_irqen", hit, 1'b1); chk("irqen_rst", d, 16'h0000);
        peek(16'hBF05, d, dn); chk("hit_above", hit, 1'b0); chk("rdata_above", d, 16'h0000);
        peek(16'hBEFF, d, dn); chk("hit_below", hit, 1'b0);

        // TX show-ahead ordering
        cpu_wr(16'hBF00, 16'h0041);
        cpu_wr(16'hBF00, 16'h0042);
        chk("tx_valid_q", tx_valid, 2'b01);
        chk("tx_head_41", tx_data[7:0], 8'h41);
        tx_ready = 2'b01;
        cyc(); chk("tx_head_42", tx_data[7:0], 8'h42); chk("tx_valid_42", tx_valid[0], 1'b1);
        cyc(); chk("tx_drained", tx_valid, 2'b00);
        tx_ready = 2'b00;

        // TX overflow and sticky flag clear
        for (int i = 1; i <= 5; i++) cpu_wr(16'hBF00, 16'(i));
        cpu_rd(16'hBF01, d, dn); chk("tx_ovf_status", d, 16'h0008);
        cpu_rd(16'hBF01, d, dn); chk("tx_ovf_cleared", d, 16'h0000);
        chk("ch1_tx_idle", tx_valid[1], 1'b0);
        tx_ready = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("tx_ovf_drain", tx_data[7:0], 8'(i));
            cyc();
        end
        chk("tx_ovf_empty", tx_valid, 2'b00);
        tx_ready = 2'b00;

        // RX backpressure on ch1
        rx_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            rx_data[15:8] = 8'(8'h10 + i);
            #1 chk("rx_ready_space", rx_ready[1], 1'b1);
            cyc();
        end
        rx_data[15:8] = 8'h14;
        #1 chk("rx_ready_full", rx_ready[1], 1'b0);
        rx_valid = 2'b00;
        peek(16'hBF03, d, dn); chk("rx_full_status", d, 16'h0003);
        for (int i = 0; i < 4; i++) begin
            cpu_rd(16'hBF02, d, dn); chk("rx_bp_read", d, 16'(8'h10 + i));
        end
        rx_valid = 2'b10;
        cyc();
        rx_valid = 2'b00;
        cpu_rd(16'hBF02, d, dn); chk("rx_refill", d, 16'h0014);
        cpu_rd(16'hBF02, d, dn); chk("rx_empty_read", d, 16'h0000);
        peek(16'hBF03, d, dn); chk("rx_empty_status", d, 16'h0001);

        // No-backpressure drop rules on ch0
        do_reset();
        rx_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            rx_data[7:0] = 8'(8'hA0 + i);
            cyc();
        end
        rx_data[7:0] = 8'hA4;
        cpu_rd(16'hBF00, d, dn); chk("nb_pop_push", dn, 16'h00A0);
        rx_valid = 2'b00;
        peek(16'hBF01, d, dn); chk("nb_no_ovf", dn, 16'h0003);
        rx_valid = 2'b01; rx_data[7:0] = 8'hA5;
        cyc();
        rx_valid = 2'b00;
        peek(16'hBF01, d, dn); chk("nb_ovf_set", dn, 16'h0007);
        rx_valid = 2'b01; rx_data[7:0] = 8'hA6;
        cpu_rd(16'hBF01, d, dn); chk("nb_ovf_read", dn, 16'h0007);
        rx_valid = 2'b00;
        peek(16'hBF01, d, dn); chk("nb_set_wins", dn, 16'h0007);
        cpu_rd(16'hBF01, d, dn); chk("nb_ovf_read2", dn, 16'h0007);
        peek(16'hBF01, d, dn); chk("nb_ovf_clr", dn, 16'h0003);
        for (int i = 1; i <= 4; i++) begin
            cpu_rd(16'hBF00, d, dn); chk("nb_drain", dn, 16'(8'hA0 + i));
        end

        // Interrupt latency
        do_reset();
        cpu_wr(16'hBF04, 16'hFFFF);
        cpu_rd(16'hBF04, d, dn); chk("irqen_mask", d, 16'h0003);
        cpu_wr(16'hBF04, 16'h0002);
        cpu_rd(16'hBF04, d, dn); chk("irqen_rd", d, 16'h0002);
        rx_valid = 2'b01; rx_data = 16'h0077;
        cyc();
        rx_valid = 2'b00;
        cyc(); chk("irq_masked_ch0", irq, 1'b0);
        rx_valid = 2'b10; rx_data = 16'h5500;
        cyc();
        rx_valid = 2'b00;
        chk("irq_latency", irq, 1'b0);
        cyc(); chk("irq_set", irq, 1'b1);
        cpu_rd(16'hBF02, d, dn); chk("irq_byte", d, 16'h0055);
        chk("irq_hold", irq, 1'b1);
        cyc(); chk("irq_clear", irq, 1'b0);

        // Reset with traffic queued everywhere
        do_reset();
        cpu_wr(16'hBF04, 16'h0003);
        rx_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            rx_data = 16'(16'h2120 + 16'(i * 16'h0101));
            cpu_wr(16'hBF00, 16'(8'h30 + i));
            cpu_wr(16'hBF02, 16'(8'h40 + i));
            rx_valid = 2'b00;
        end
        rx_valid = 2'b11; rx_data = 16'h2323;
        cyc(); cyc();
        rx_valid = 2'b00;
        chk("preq_tx_valid", tx_valid, 2'b11);
        chk("preq_irq", irq, 1'b1);
        rst = 1'b1; tx_ready = 2'b11; rx_valid = 2'b11;
        #1 chk("rst_gate_tx_valid", tx_valid, 2'b00);
        cyc();
        rst = 1'b0; tx_ready = 2'b00; rx_valid = 2'b00;
        #1 chk("rst_mid_tx_valid", tx_valid, 2'b00);
        chk("rst_mid_irq", irq, 1'b0);
        peek(16'hBF01, d, dn); chk("rst_mid_st0", d, 16'h0001);
        peek(16'hBF03, d, dn); chk("rst_mid_st1", d, 16'h0001);
        peek(16'hBF00, d, dn); chk("rst_mid_data", d, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
